// File: rtl/skid_buf_pkg.sv
// Shared types and constants for the skid_buf register slice.
package skid_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

  localparam int unsigned SKID_DEPTH = 2;

  // Number of beats held in each state.
  function automatic logic [1:0] occupancy(input skid_state_e s);
    case (s)
      EMPTY:   occupancy = 2'd0;
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/dffer.sv
// Load-enabled D flop with async active-low reset to zero.
module dffer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dffr.sv
// D flop with async active-low reset to zero.
module dffr #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/dffrc.sv
// D flop with async active-low reset to a configurable constant.
module dffrc #(
  parameter int unsigned   W         = 1,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RESET_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/dffrh.sv
// D flop with async active-low reset to all-ones.
module dffrh #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '1;
    else        q <= d;
  end

endmodule

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer with registered valid, data and ready.
// Optional stall counter enabled by defining SKID_BUF_PERF_EN.
module skid_buf
  import skid_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] dat_o
`ifdef SKID_BUF_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
`endif
);

  logic [1:0]            w_state_q;
  skid_state_e           r_state;
  skid_state_e           w_state_nxt;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_main_en;
  logic                  w_main_sel_skid;
  logic                  w_skid_en;
  logic                  w_valid_nxt;
  logic                  w_ready_nxt;
  logic [DATA_WIDTH-1:0] w_main_d;
  logic [DATA_WIDTH-1:0] r_skid;

  assign r_state    = skid_state_e'(w_state_q);
  assign w_in_fire  = valid_i & ready_o;
  assign w_out_fire = valid_o & ready_i;

  // Next state and register load enables; flush overrides every transfer.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_en       = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_en       = 1'b0;
    if (flush_i) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (valid_i) begin
            w_main_en   = 1'b1;
            w_state_nxt = BUSY;
          end
        end
        BUSY: begin
          case ({w_in_fire, w_out_fire})
            2'b11: w_main_en = 1'b1;
            2'b10: begin
              w_skid_en   = 1'b1;
              w_state_nxt = FULL;
            end
            2'b01: w_state_nxt = EMPTY;
            default: w_state_nxt = BUSY;
          endcase
        end
        FULL: begin
          if (ready_i) begin
            w_main_en       = 1'b1;
            w_main_sel_skid = 1'b1;
            w_state_nxt     = BUSY;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  assign w_valid_nxt = (w_state_nxt != EMPTY);
  assign w_ready_nxt = (occupancy(w_state_nxt) < 2'(SKID_DEPTH));
  assign w_main_d    = w_main_sel_skid ? r_skid : dat_i;

  dffrc #(.W(2), .RESET_VAL(2'(EMPTY))) u_state (
    .clk(clk_i), .rst_n(rst_n_i), .d(w_state_nxt), .q(w_state_q)
  );

  dffrh #(.W(1)) u_ready (
    .clk(clk_i), .rst_n(rst_n_i), .d(w_ready_nxt), .q(ready_o)
  );

  dffr #(.W(1)) u_valid (
    .clk(clk_i), .rst_n(rst_n_i), .d(w_valid_nxt), .q(valid_o)
  );

  dffer #(.W(DATA_WIDTH)) u_main (
    .clk(clk_i), .rst_n(rst_n_i), .en(w_main_en), .d(w_main_d), .q(dat_o)
  );

  dffer #(.W(DATA_WIDTH)) u_skid (
    .clk(clk_i), .rst_n(rst_n_i), .en(w_skid_en), .d(dat_i), .q(r_skid)
  );

`ifdef SKID_BUF_PERF_EN
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  // Saturating count of cycles where a beat waits on downstream.
  always_comb begin
    w_cnt_nxt = stall_cnt_o;
    if (flush_i)
      w_cnt_nxt = '0;
    else if (valid_o && !ready_i && !(&stall_cnt_o))
      w_cnt_nxt = stall_cnt_o + CNT_WIDTH'(1);
  end

  dffr #(.W(CNT_WIDTH)) u_stall_cnt (
    .clk(clk_i), .rst_n(rst_n_i), .d(w_cnt_nxt), .q(stall_cnt_o)
  );
`else
  logic [CNT_WIDTH-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

`ifndef SV_ASSRT_DISABLE
  a_handshake_known: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) !$isunknown({valid_i, ready_i})
  );
`endif

endmodule

// File: tb/tb_skid_buf.sv
// Randomized scoreboard bench for skid_buf against a two-slot FIFO model.
module tb_skid_buf;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          valid_in;
  logic          ready_out;
  logic [DW-1:0] dat_in;
  logic          valid_out;
  logic          ready_in;
  logic [DW-1:0] dat_out;
`ifdef SKID_BUF_PERF_EN
  logic [CW-1:0] stall_cnt;
`endif

  skid_buf #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .valid_i (valid_in),
    .ready_o (ready_out),
    .dat_i   (dat_in),
    .valid_o (valid_out),
    .ready_i (ready_in),
    .dat_o   (dat_out)
`ifdef SKID_BUF_PERF_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_q[$];
  int            m_occ = 0;
  int            m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a two-slot FIFO whose ready is "not full" as of the last edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_occ = 0;
      m_cnt = 0;
    end else begin
      bit out_f;
      bit in_f;
      out_f = (m_occ > 0) && ready_in;
      in_f  = valid_in && (m_occ < 2);
      if (flush) begin
        exp_q.delete();
        m_occ = 0;
        m_cnt = 0;
      end else begin
        if ((m_occ > 0) && !ready_in && (m_cnt < (1 << CW) - 1)) m_cnt++;
        m_occ = m_occ - int'(out_f) + int'(in_f);
        if (in_f) exp_q.push_back(dat_in);
      end
    end
  end

  // Monitor: compares presented outputs and pops beats as downstream takes them.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid_o", 64'(valid_out), 64'd0);
      check("rst_ready_o", 64'(ready_out), 64'd1);
      check("rst_dat_o", 64'(dat_out), 64'd0);
`ifdef SKID_BUF_PERF_EN
      check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    end else begin
      check("valid_o", 64'(valid_out), 64'(m_occ > 0));
      check("ready_o", 64'(ready_out), 64'(m_occ < 2));
`ifdef SKID_BUF_PERF_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`endif
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("dat_o_unexpected_beat", 64'(dat_out), 64'hDEAD_0000_0000_0000);
        end else begin
          check("dat_o", 64'(dat_out), 64'(exp_q[0]));
          if (ready_in) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    valid_in = v;
    dat_in   = d;
    ready_in = r;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    dat_in   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b1, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    // Backpressure fills both entries, then drains in order
    drive(1'b1, DW'(32'hA), 1'b0, 1'b0);
    drive(1'b1, DW'(32'hB), 1'b0, 1'b0);
    drive(1'b1, DW'(32'hC), 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Stall stability
    drive(1'b1, DW'(32'h55), 1'b0, 1'b0);
    repeat (5) drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Flush while full, beat presented with flush is dropped
    drive(1'b1, DW'(32'h1), 1'b0, 1'b0);
    drive(1'b1, DW'(32'h2), 1'b0, 1'b0);
    drive(1'b1, DW'(32'h3), 1'b0, 1'b1);
    check("flush_valid_o", 64'(valid_out), 64'd0);
    check("flush_ready_o", 64'(ready_out), 64'd1);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream while full
    drive(1'b1, DW'(32'h9), 1'b0, 1'b0);
    drive(1'b1, DW'(32'h10), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid_o", 64'(valid_out), 64'd0);
    check("async_rst_ready_o", 64'(ready_out), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, DW'(32'h77), 1'b1, 1'b0);
    check("post_rst_valid_o", 64'(valid_out), 64'd1);
    check("post_rst_dat_o", 64'(dat_out), 64'h77);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Long stall saturates the counter, flush clears it
    drive(1'b1, DW'(32'h5), 1'b0, 1'b0);
    repeat (20) drive(1'b0, '0, 1'b0, 1'b0);
`ifdef SKID_BUF_PERF_EN
    check("stall_cnt_sat", 64'(stall_cnt), 64'hF);
`endif
    drive(1'b0, '0, 1'b0, 1'b1);
`ifdef SKID_BUF_PERF_EN
    check("stall_cnt_flush", 64'(stall_cnt), 64'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
    end
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
